// File: rtl/port_egress.sv
// port_egress: one egress leg of a 4-port switch fabric.
// Packets whose target mask includes this port (and are not ERR class) are
// stored in a first-word-fall-through queue and presented to the endpoint.
// All other consumed packets are counted as drops. A small FSM tracks the
// transmit handshake and flags an endpoint that stalls for too long.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never waits on ready, and a source holding valid keeps its
// payload stable until the transfer. in_ready depends only on registered
// occupancy, never combinationally on out_ready.
module port_egress #(
    parameter int PORT_ID   = 0,
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_pkt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pkt,
    output logic [1:0]  out_type,
    output logic [1:0]  tx_state,
    output logic [3:0]  count,
    output logic [7:0]  drop_cnt,
    output logic        stall_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    // Packet classes derived from target-mask popcount
    localparam logic [1:0] CLS_ERR = 2'b00;
    localparam logic [1:0] CLS_SDP = 2'b01;
    localparam logic [1:0] CLS_MDP = 2'b10;
    localparam logic [1:0] CLS_BDP = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ROUTE    = 2'b01,
        ARB_WAIT = 2'b10,
        TRANSMIT = 2'b11
    } tx_state_t;

    tx_state_t      state;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [3:0]     count_q;
    logic [3:0]     count_next;
    logic [3:0]     stall_cnt;
    logic [7:0]     drop_q;
    logic           stall_q;
    logic           accept;
    logic           keep;
    logic           push;
    logic           pop;
    logic           discard;
    logic [1:0]     in_class;

    // Popcount of the 4-bit target mask mapped onto the packet class
    function automatic logic [1:0] classify(input logic [3:0] t);
        logic [2:0] n;
        n = {2'b00, t[0]} + {2'b00, t[1]} + {2'b00, t[2]} + {2'b00, t[3]};
        case (n)
            3'd0:       classify = CLS_ERR;
            3'd1:       classify = CLS_SDP;
            3'd2, 3'd3: classify = CLS_MDP;
            default:    classify = CLS_BDP;
        endcase
    endfunction

    // Input filtering and queue handshake decode
    always_comb begin
        in_ready   = (count_q != FULL_CNT);
        out_valid  = (count_q != 4'd0);
        in_class   = classify(in_pkt[11:8]);
        accept     = in_valid & in_ready;
        keep       = in_pkt[8 + PORT_ID] & (in_class != CLS_ERR);
        push       = accept & keep;
        discard    = accept & ~keep;
        pop        = out_valid & out_ready;
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + 4'd1;
            2'b01:   count_next = count_q - 4'd1;
            default: count_next = count_q;
        endcase
    end

    // Head entry is shown directly; zero when the queue is empty
    always_comb begin
        out_pkt  = out_valid ? mem[rd_ptr] : 16'h0000;
        out_type = classify(out_pkt[11:8]);
        tx_state = state;
        count    = count_q;
        drop_cnt = drop_q;
        stall_err = stall_q;
    end

    // Storage array: data only, occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pkt;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_next;
        end
    end

    // Saturating count of packets consumed but not stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (discard && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // Transmit FSM: next state from next occupancy and current out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state <= (count_next != 4'd0) ? TRANSMIT : IDLE;
                end
                TRANSMIT: begin
                    if (!out_ready) begin
                        state <= ARB_WAIT;
                    end else if (count_next == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        state <= TRANSMIT;
                    end
                end
                ARB_WAIT: begin
                    if (out_ready) begin
                        state <= (count_next != 4'd0) ? TRANSMIT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall watchdog: counts stalled ARB_WAIT cycles, error is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 4'd0;
            stall_q   <= 1'b0;
        end else begin
            if (pop) begin
                stall_cnt <= 4'd0;
            end else if (state == ARB_WAIT && !out_ready) begin
                if (stall_cnt != 4'hF) begin
                    stall_cnt <= stall_cnt + 4'd1;
                end
                if (int'(stall_cnt) + 1 >= STALL_MAX) begin
                    stall_q <= 1'b1;
                end
            end
        end
    end

endmodule
